// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared owner encoding, default arbitration limits and counter sizing.
`default_nettype none

package dmem_arb_pkg;

   typedef enum logic {
      CORE = 1'b0,
      DMA  = 1'b1
   } owner_t;

   localparam int DEF_MAX_BURST    = 4;
   localparam int DEF_STARVE_LIMIT = 8;

   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/arb_sat_counter.sv
// arb_sat_counter: up-counter with synchronous clear that holds at MAX instead of wrapping.
`default_nettype none

module arb_sat_counter #(
   parameter int           W   = 4,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != MAX)) begin
         count <= count + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares data_mem between the core load/store port and a DMA port.
// Optional DMEM_ARB_STATS_EN adds saturating stall_cycles / dma_beats counters.
`default_nettype none

module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int MAX_BURST    = DEF_MAX_BURST,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic [DW-1:0] core_rdata,
   output logic          core_stall,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   input  logic          dma_last,
   output logic          dma_gnt,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_rvalid,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]   stall_cycles,
   output logic [15:0]   dma_beats
`endif
);

   localparam int BW = cnt_width(MAX_BURST);
   localparam int SW = cnt_width(STARVE_LIMIT);

   owner_t        state;
   owner_t        next_state;
   logic [BW-1:0] beat_cnt;
   logic [SW-1:0] starve_cnt;
   logic          beat;
   logic          burst_end;
   logic          starve_hit;
   logic          starve_inc;
   logic          starve_clr;
   logic          beat_clr;

   assign beat       = (state == DMA) && dma_req;
   assign burst_end  = beat && (dma_last || (beat_cnt == BW'(MAX_BURST - 1)));
   assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= CORE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      mem_we     = 1'b0;
      mem_addr   = core_addr;
      mem_wd     = core_wdata;
      core_rdata = mem_rd;
      core_stall = 1'b0;
      dma_gnt    = 1'b0;
      case (state)
         CORE: begin
            mem_we = core_req && core_we;
            if (dma_req && (!core_req || starve_hit)) begin
               next_state = DMA;
            end
         end
         DMA: begin
            mem_addr   = dma_addr;
            mem_wd     = dma_wdata;
            dma_gnt    = dma_req;
            mem_we     = dma_req && dma_we;
            core_stall = core_req;
            core_rdata = '0;
            if (!dma_req || burst_end) begin
               next_state = CORE;
            end
         end
         default: next_state = CORE;
      endcase
      // Reset is asynchronous, so block writes for its whole duration, not just after the edge.
      if (reset) begin
         mem_we = 1'b0;
      end
   end

   assign starve_inc = (state == CORE) && dma_req;
   assign starve_clr = (state != CORE) || !dma_req || (next_state == DMA);
   assign beat_clr   = (state == DMA) && (next_state == CORE);

   arb_sat_counter #(
      .W   (SW),
      .MAX (SW'(STARVE_LIMIT - 1))
   ) u_starve_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (starve_inc),
      .clr   (starve_clr),
      .count (starve_cnt)
   );

   arb_sat_counter #(
      .W   (BW),
      .MAX (BW'(MAX_BURST - 1))
   ) u_beat_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (beat),
      .clr   (beat_clr),
      .count (beat_cnt)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dma_rvalid <= 1'b0;
         dma_rdata  <= '0;
      end else begin
         dma_rvalid <= beat && !dma_we;
         if (beat && !dma_we) begin
            dma_rdata <= mem_rd;
         end
      end
   end

`ifdef DMEM_ARB_STATS_EN
   arb_sat_counter #(
      .W   (16),
      .MAX (16'hFFFF)
   ) u_stall_stat (
      .clock (clock),
      .reset (reset),
      .inc   (core_stall),
      .clr   (1'b0),
      .count (stall_cycles)
   );

   arb_sat_counter #(
      .W   (16),
      .MAX (16'hFFFF)
   ) u_beat_stat (
      .clock (clock),
      .reset (reset),
      .inc   (beat),
      .clr   (1'b0),
      .count (dma_beats)
   );
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: cycle-by-cycle vector table plus directed starvation and async-reset sequences.
`default_nettype none

module tb_dmem_arbiter;

   logic        clock;
   logic        reset;
   logic        core_req;
   logic        core_we;
   logic [31:0] core_addr;
   logic [31:0] core_wdata;
   logic [31:0] core_rdata;
   logic        core_stall;
   logic        dma_req;
   logic        dma_we;
   logic [31:0] dma_addr;
   logic [31:0] dma_wdata;
   logic        dma_last;
   logic        dma_gnt;
   logic [31:0] dma_rdata;
   logic        dma_rvalid;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stall_cycles;
   logic [15:0] dma_beats;
`endif

   int checks = 0;
   int errors = 0;

   dmem_arbiter #(
      .AW           (32),
      .DW           (32),
      .MAX_BURST    (4),
      .STARVE_LIMIT (8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .core_req     (core_req),
      .core_we      (core_we),
      .core_addr    (core_addr),
      .core_wdata   (core_wdata),
      .core_rdata   (core_rdata),
      .core_stall   (core_stall),
      .dma_req      (dma_req),
      .dma_we       (dma_we),
      .dma_addr     (dma_addr),
      .dma_wdata    (dma_wdata),
      .dma_last     (dma_last),
      .dma_gnt      (dma_gnt),
      .dma_rdata    (dma_rdata),
      .dma_rvalid   (dma_rvalid),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wd       (mem_wd),
      .mem_rd       (mem_rd)
`ifdef DMEM_ARB_STATS_EN
      ,
      .stall_cycles (stall_cycles),
      .dma_beats    (dma_beats)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        cr, cw;
      logic [31:0] caddr, cwd;
      logic        dr, dw;
      logic [31:0] daddr, dwd;
      logic        dl;
      logic [31:0] mrd;
      logic        e_we;
      logic [31:0] e_addr, e_wd;
      logic        e_stall, e_gnt, e_rv;
      logic [31:0] e_rdata, e_crd;
   } vec_t;

   function automatic vec_t mk(
      input logic cr, input logic cw, input logic [31:0] caddr, input logic [31:0] cwd,
      input logic dr, input logic dw, input logic [31:0] daddr, input logic [31:0] dwd,
      input logic dl, input logic [31:0] mrd,
      input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wd,
      input logic e_stall, input logic e_gnt, input logic e_rv,
      input logic [31:0] e_rdata, input logic [31:0] e_crd);
      vec_t v;
      v.cr = cr; v.cw = cw; v.caddr = caddr; v.cwd = cwd;
      v.dr = dr; v.dw = dw; v.daddr = daddr; v.dwd = dwd; v.dl = dl; v.mrd = mrd;
      v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
      v.e_stall = e_stall; v.e_gnt = e_gnt; v.e_rv = e_rv;
      v.e_rdata = e_rdata; v.e_crd = e_crd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   vec_t vecs[19];

   initial begin
      //                core: req we addr wdata         dma: req we addr wdata last  mem_rd
      //                expect: we addr wdata stall gnt rvalid rdata core_rdata
      // DMA write burst of 3 with core idle
      vecs[0]  = mk(0,0,32'h0,32'h0,          1,1,32'h10,32'h11,0, 32'h0,
                    0,32'h0,32'h0,0,0,0,32'h0,32'h0);
      vecs[1]  = mk(0,0,32'h0,32'h0,          1,1,32'h10,32'h11,0, 32'h0,
                    1,32'h10,32'h11,0,1,0,32'h0,32'h0);
      vecs[2]  = mk(0,0,32'h0,32'h0,          1,1,32'h14,32'h22,0, 32'h0,
                    1,32'h14,32'h22,0,1,0,32'h0,32'h0);
      vecs[3]  = mk(0,0,32'h0,32'h0,          1,1,32'h18,32'h33,1, 32'h0,
                    1,32'h18,32'h33,0,1,0,32'h0,32'h0);
      vecs[4]  = mk(0,0,32'h0,32'h0,          0,0,32'h0,32'h0,0,   32'h55,
                    0,32'h0,32'h0,0,0,0,32'h0,32'h55);
      // Read burst capped at 4 beats, stalling a store to 0x20
      vecs[5]  = mk(0,0,32'h0,32'h0,          1,0,32'h40,32'h0,0,  32'h10000000,
                    0,32'h0,32'h0,0,0,0,32'h0,32'h10000000);
      vecs[6]  = mk(0,0,32'h0,32'h0,          1,0,32'h40,32'h0,0,  32'hA0,
                    0,32'h40,32'h0,0,1,0,32'h0,32'h0);
      vecs[7]  = mk(1,1,32'h20,32'hDEADBEEF,  1,0,32'h44,32'h0,0,  32'hA1,
                    0,32'h44,32'h0,1,1,1,32'hA0,32'h0);
      vecs[8]  = mk(1,1,32'h20,32'hDEADBEEF,  1,0,32'h48,32'h0,0,  32'hA2,
                    0,32'h48,32'h0,1,1,1,32'hA1,32'h0);
      vecs[9]  = mk(1,1,32'h20,32'hDEADBEEF,  1,0,32'h4C,32'h0,0,  32'hA3,
                    0,32'h4C,32'h0,1,1,1,32'hA2,32'h0);
      vecs[10] = mk(1,1,32'h20,32'hDEADBEEF,  1,0,32'h50,32'h0,0,  32'h0,
                    1,32'h20,32'hDEADBEEF,0,0,1,32'hA3,32'h0);
      vecs[11] = mk(0,0,32'h0,32'h0,          1,0,32'h50,32'h0,0,  32'h77,
                    0,32'h0,32'h0,0,0,0,32'hA3,32'h77);
      vecs[12] = mk(0,0,32'h0,32'h0,          1,0,32'h50,32'h0,0,  32'hA4,
                    0,32'h50,32'h0,0,1,0,32'hA3,32'h0);
      vecs[13] = mk(0,0,32'h0,32'h0,          1,0,32'h54,32'h0,1,  32'hA5,
                    0,32'h54,32'h0,0,1,1,32'hA4,32'h0);
      vecs[14] = mk(0,0,32'h0,32'h0,          0,0,32'h0,32'h0,0,   32'h0,
                    0,32'h0,32'h0,0,0,1,32'hA5,32'h0);
      vecs[15] = mk(0,0,32'h0,32'h0,          0,0,32'h0,32'h0,0,   32'h0,
                    0,32'h0,32'h0,0,0,0,32'hA5,32'h0);
      // DMA drops its request while owning: store is stalled, not written, then CORE resumes
      vecs[16] = mk(0,0,32'h0,32'h0,          1,1,32'h60,32'h66,0, 32'h0,
                    0,32'h0,32'h0,0,0,0,32'hA5,32'h0);
      vecs[17] = mk(1,1,32'h24,32'h12345678,  0,1,32'h60,32'h66,0, 32'h0,
                    0,32'h60,32'h66,1,0,0,32'hA5,32'h0);
      vecs[18] = mk(1,0,32'h28,32'h0,         0,0,32'h0,32'h0,0,   32'h99,
                    0,32'h28,32'h0,0,0,0,32'hA5,32'h99);

      reset = 1'b1;
      core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
      dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_last = 0; mem_rd = '0;
      #1;
      chk("reset mem_we", {31'b0, mem_we}, 32'h0);
      chk("reset dma_gnt", {31'b0, dma_gnt}, 32'h0);
      chk("reset core_stall", {31'b0, core_stall}, 32'h0);
      chk("reset dma_rvalid", {31'b0, dma_rvalid}, 32'h0);
      chk("reset dma_rdata", dma_rdata, 32'h0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      for (int i = 0; i < 19; i++) begin
         @(posedge clock);
         #1;
         core_req = vecs[i].cr; core_we = vecs[i].cw;
         core_addr = vecs[i].caddr; core_wdata = vecs[i].cwd;
         dma_req = vecs[i].dr; dma_we = vecs[i].dw;
         dma_addr = vecs[i].daddr; dma_wdata = vecs[i].dwd;
         dma_last = vecs[i].dl; mem_rd = vecs[i].mrd;
         @(negedge clock);
         chk($sformatf("row%0d mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].e_we});
         chk($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].e_addr);
         chk($sformatf("row%0d mem_wd", i), mem_wd, vecs[i].e_wd);
         chk($sformatf("row%0d core_stall", i), {31'b0, core_stall}, {31'b0, vecs[i].e_stall});
         chk($sformatf("row%0d dma_gnt", i), {31'b0, dma_gnt}, {31'b0, vecs[i].e_gnt});
         chk($sformatf("row%0d dma_rvalid", i), {31'b0, dma_rvalid}, {31'b0, vecs[i].e_rv});
         chk($sformatf("row%0d dma_rdata", i), dma_rdata, vecs[i].e_rdata);
         chk($sformatf("row%0d core_rdata", i), core_rdata, vecs[i].e_crd);
      end
`ifdef DMEM_ARB_STATS_EN
      // 3 stalled cycles in the capped burst plus 1 while DMA released; 3 + 6 beats
      chk("stats stall_cycles", {16'b0, stall_cycles}, 32'd4);
      chk("stats dma_beats", {16'b0, dma_beats}, 32'd9);
`endif

      // Both requesters always active: 8 CORE cycles, then a 4-beat DMA burst, repeating
      for (int k = 0; k < 24; k++) begin
         @(posedge clock);
         #1;
         core_req = 1; core_we = 0; core_addr = 32'h30; core_wdata = '0;
         dma_req = 1; dma_we = 0; dma_addr = 32'h90; dma_wdata = '0; dma_last = 0; mem_rd = '0;
         @(negedge clock);
         chk($sformatf("starve k%0d dma_gnt", k), {31'b0, dma_gnt}, {31'b0, (k % 12) >= 8});
         chk($sformatf("starve k%0d core_stall", k), {31'b0, core_stall}, {31'b0, (k % 12) >= 8});
      end
`ifdef DMEM_ARB_STATS_EN
      chk("stats2 stall_cycles", {16'b0, stall_cycles}, 32'd12);
      chk("stats2 dma_beats", {16'b0, dma_beats}, 32'd17);
`endif

      // Asynchronous reset in the middle of a burst
      @(posedge clock);
      #1;
      core_req = 0; core_we = 0; dma_req = 1; dma_we = 0; dma_addr = 32'h80; mem_rd = 32'hC0;
      @(posedge clock);
      #1;
      core_req = 1; core_we = 1; core_addr = 32'h34; core_wdata = 32'hCAFE0001;
      @(posedge clock);
      #1;
      dma_we = 1; dma_addr = 32'h84; dma_wdata = 32'h5555;
      #2;
      chk("pre-reset dma_gnt", {31'b0, dma_gnt}, 32'h1);
      chk("pre-reset mem_we", {31'b0, mem_we}, 32'h1);
      chk("pre-reset dma_rvalid", {31'b0, dma_rvalid}, 32'h1);
      chk("pre-reset dma_rdata", dma_rdata, 32'hC0);
      chk("pre-reset core_stall", {31'b0, core_stall}, 32'h1);
      reset = 1'b1;
      #1;
      chk("async reset dma_gnt", {31'b0, dma_gnt}, 32'h0);
      chk("async reset core_stall", {31'b0, core_stall}, 32'h0);
      chk("async reset mem_we", {31'b0, mem_we}, 32'h0);
      chk("async reset dma_rvalid", {31'b0, dma_rvalid}, 32'h0);
      chk("async reset dma_rdata", dma_rdata, 32'h0);
      @(posedge clock);
      #1;
      chk("held reset mem_we", {31'b0, mem_we}, 32'h0);
      chk("held reset core_stall", {31'b0, core_stall}, 32'h0);
`ifdef DMEM_ARB_STATS_EN
      chk("reset stall_cycles", {16'b0, stall_cycles}, 32'd0);
      chk("reset dma_beats", {16'b0, dma_beats}, 32'd0);
`endif
      reset = 1'b0;
      @(negedge clock);
      chk("post-reset core store mem_we", {31'b0, mem_we}, 32'h1);
      chk("post-reset mem_addr", mem_addr, 32'h34);
      chk("post-reset dma_gnt", {31'b0, dma_gnt}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no completion expected finish before 20000");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
